// File: rtl/dual_grant_decoder.sv
// Turns an accepted (idx1, idx2) pair into one-hot grant beats, idx1 first. Macro DUAL_GRANT_MERGED_EN merges both into one beat.
// Latency: the first beat is registered at the accepting edge. Backpressure: in_ready only in IDLE; beats hold while !grant_ready.
module dual_grant_decoder #(
    parameter int N     = 12,
    parameter int IDX_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] idx1,
    input  logic [IDX_W-1:0] idx2,
    output logic [N-1:0]     grant,
    output logic             grant_valid,
    input  logic             grant_ready,
    output logic             grant_last,
    output logic [CNT_W-1:0] grant_cnt,
    output logic             err,
    input  logic             err_clr
);

    typedef enum logic [1:0] {IDLE, G1, G2} state_t;

    localparam logic [IDX_W-1:0] N_IDX    = IDX_W'(N);
    localparam logic [IDX_W-1:0] IDX_NONE = '1;

    state_t       state_q, state_d;
    logic [N-1:0] b1_q, b1_d, b2_q, b2_d;
    logic         l1_q, l1_d;
    logic         v1, v2, inv_any, accept;
    logic [N-1:0] oh1, oh2;
    logic [N-1:0] grant_d;
    logic         grant_last_d;

    assign in_ready = (state_q == IDLE);
    assign accept   = in_valid & in_ready;

    assign v1      = (idx1 < N_IDX);
    assign v2      = (idx2 < N_IDX);
    assign inv_any = (!v1 && idx1 != IDX_NONE) || (!v2 && idx2 != IDX_NONE);
    assign oh1     = v1 ? (N'(1) << idx1) : '0;
    assign oh2     = v2 ? (N'(1) << idx2) : '0;

`ifndef DUAL_GRANT_MERGED_EN
    logic dup;
    // A duplicate second index collapses to "no second request".
    assign dup = v1 && v2 && (idx1 == idx2);
`endif

    always_comb begin
        state_d = state_q;
        b1_d    = b1_q;
        b2_d    = b2_q;
        l1_d    = l1_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
`ifdef DUAL_GRANT_MERGED_EN
                    b1_d    = oh1 | oh2;
                    b2_d    = '0;
                    l1_d    = 1'b1;
                    state_d = (v1 || v2) ? G1 : IDLE;
`else
                    b1_d    = oh1;
                    b2_d    = dup ? '0 : oh2;
                    l1_d    = dup || !v2;
                    state_d = v1 ? G1 : ((v2 && !dup) ? G2 : IDLE);
`endif
                end
            end
            G1: begin
                if (grant_ready) state_d = (b2_q != '0) ? G2 : IDLE;
            end
            G2: begin
                if (grant_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        grant_d      = '0;
        grant_last_d = 1'b0;
        if (state_d == G1) begin
            grant_d      = b1_d;
            grant_last_d = l1_d;
        end else if (state_d == G2) begin
            grant_d      = b2_d;
            grant_last_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            b1_q        <= '0;
            b2_q        <= '0;
            l1_q        <= 1'b0;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_last  <= 1'b0;
            grant_cnt   <= '0;
            err         <= 1'b0;
        end else begin
            state_q     <= state_d;
            b1_q        <= b1_d;
            b2_q        <= b2_d;
            l1_q        <= l1_d;
            grant       <= grant_d;
            grant_valid <= (state_d != IDLE);
            grant_last  <= grant_last_d;
            if (grant_valid && grant_ready) grant_cnt <= grant_cnt + CNT_W'(1);
            // A new out-of-range index wins over a same-cycle clear.
            if (accept && inv_any) err <= 1'b1;
            else if (err_clr)      err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dual_grant_decoder.sv
// Randomized and directed checks of dual_grant_decoder against a pending-beat queue model.
module tb_dual_grant_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  idx1, idx2;
    logic [11:0] grant;
    logic        grant_valid;
    logic        grant_ready;
    logic        grant_last;
    logic [15:0] grant_cnt;
    logic        err;
    logic        err_clr;

    int n_cmp = 0;
    int n_err = 0;

    // Model: beats still owed to downstream, in order.
    logic [11:0] q_g[$];
    logic        q_l[$];
    logic [15:0] m_cnt;
    logic        m_err;

    always #5 clk = ~clk;

    dual_grant_decoder dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .idx1(idx1), .idx2(idx2), .grant(grant), .grant_valid(grant_valid),
        .grant_ready(grant_ready), .grant_last(grant_last), .grant_cnt(grant_cnt),
        .err(err), .err_clr(err_clr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_pair(input logic [3:0] a, input logic [3:0] b);
        bit va, vb;
        va = (a < 12);
        vb = (b < 12);
        if (va && vb && a == b) vb = 0;
`ifdef DUAL_GRANT_MERGED_EN
        if (va || vb) begin
            q_g.push_back((va ? (12'd1 << a) : 12'd0) | (vb ? (12'd1 << b) : 12'd0));
            q_l.push_back(1'b1);
        end
`else
        if (va) begin
            q_g.push_back(12'd1 << a);
            q_l.push_back(!vb);
        end
        if (vb) begin
            q_g.push_back(12'd1 << b);
            q_l.push_back(1'b1);
        end
`endif
    endtask

    task automatic check_outputs();
        bit busy;
        busy = (q_g.size() != 0);
        chk("in_ready", in_ready, !busy);
        chk("grant_valid", grant_valid, busy);
        chk("grant", grant, busy ? q_g[0] : 12'd0);
        chk("grant_last", grant_last, busy ? q_l[0] : 1'b0);
        chk("grant_cnt", grant_cnt, m_cnt);
        chk("err", err, m_err);
    endtask

    // Called at a falling edge: check, drive, advance the model over the next rising edge.
    task automatic step(input logic iv, input logic [3:0] a, input logic [3:0] b,
                        input logic gr, input logic clr);
        bit rdy, bad;
        check_outputs();
        in_valid    = iv;
        idx1        = a;
        idx2        = b;
        grant_ready = gr;
        err_clr     = clr;
        rdy = (q_g.size() == 0);
        if (!rdy && gr) begin
            void'(q_g.pop_front());
            void'(q_l.pop_front());
            m_cnt = m_cnt + 16'd1;
        end
        bad = (a >= 12 && a != 4'hF) || (b >= 12 && b != 4'hF);
        if (iv && rdy) push_pair(a, b);
        if (iv && rdy && bad) m_err = 1'b1;
        else if (clr)         m_err = 1'b0;
        @(negedge clk);
    endtask

    task automatic model_reset();
        q_g.delete();
        q_l.delete();
        m_cnt = 16'd0;
        m_err = 1'b0;
    endtask

    initial begin
        logic [3:0] ha, hb;
        bit holding;
        rst_n = 1'b0; in_valid = 0; idx1 = 0; idx2 = 0; grant_ready = 0; err_clr = 0;
        model_reset();
        #2;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_grant", grant, 12'd0);
        chk("rst_valid", grant_valid, 1'b0);
        chk("rst_cnt", grant_cnt, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Two-beat pair with ready held high.
        step(1, 4'd3, 4'd7, 1, 0);
        chk("t1_beat0", grant, 12'h008);
        chk("t1_last0", grant_last, 1'b0);
        step(0, 0, 0, 1, 0);
        chk("t1_beat1", grant, 12'h080);
        chk("t1_last1", grant_last, 1'b1);
        step(0, 0, 0, 1, 0);
        chk("t1_cnt", grant_cnt, 16'd2);
        chk("t1_ready", in_ready, 1'b1);

        step(1, 4'd11, 4'hF, 1, 0);
        chk("t2_beat", grant, 12'h800);
        step(0, 0, 0, 1, 0);
        chk("t2_err", err, 1'b0);

        step(1, 4'd5, 4'd5, 1, 0);
        chk("t3_dup", grant, 12'h020);
        chk("t3_last", grant_last, 1'b1);
        step(1, 4'hF, 4'hF, 1, 0);
        chk("t3_none_ready", in_ready, 1'b1);
        chk("t3_none_valid", grant_valid, 1'b0);

        step(1, 4'd13, 4'd2, 1, 0);
        chk("t4_beat", grant, 12'h004);
        chk("t4_err", err, 1'b1);
        step(0, 0, 0, 1, 1);
        chk("t4_clr", err, 1'b0);
        step(0, 0, 0, 1, 0);
        step(1, 4'd12, 4'hF, 1, 1);
        chk("t4_set_wins", err, 1'b1);
        step(0, 0, 0, 1, 1);

        // Backpressure in G1, then reset while the second beat is pending.
        step(1, 4'd3, 4'd7, 0, 0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_grant", grant, 12'h008);
            chk("bp_in_ready", in_ready, 1'b0);
            step(1, 4'd1, 4'd2, 0, 0);
        end
        step(0, 0, 0, 1, 0);
        chk("bp_g2", grant, 12'h080);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_grant", grant, 12'd0);
        chk("mid_rst_valid", grant_valid, 1'b0);
        chk("mid_rst_cnt", grant_cnt, 16'd0);
        model_reset();
        in_valid = 0; grant_ready = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Random traffic; a pending pair is held until accepted.
        holding = 0; ha = 0; hb = 0;
        for (int i = 0; i < 3000; i++) begin
            bit iv;
            if (!holding) begin
                ha = 4'($urandom_range(0, 15));
                hb = ($urandom_range(0, 3) == 0) ? ha : 4'($urandom_range(0, 15));
                iv = ($urandom_range(0, 2) != 0);
            end else begin
                iv = 1;
            end
            holding = iv && (q_g.size() != 0);
            step(iv, ha, hb, ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
        end
        check_outputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
